// File: rtl/flag_unit.sv
// Architectural condition-flag register {V,N,Z} with same-cycle forwarding.
// Captures flags from flag-setting EX instructions and counts flag updates.
module flag_unit #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_ovfl,
  input  logic             stall,
  input  logic             flush,
  output logic [2:0]       flags_out,
  output logic [2:0]       flags_fwd,
  output logic             flags_wr,
  output logic [CNT_W-1:0] upd_count
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  logic [2:0]       flags_q, flags_d;
  logic             wr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_nzv, is_z, upd, res_zero;

  // NOTE: every signal gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    is_nzv   = 1'b0;
    is_z     = 1'b0;
    res_zero = (alu_result == '0);
    unique case (ex_opcode)
      OP_ADD, OP_SUB:                 is_nzv = 1'b1;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: is_z   = 1'b1;
      default: ;
    endcase

    upd     = ex_valid & ~stall & ~flush & (is_nzv | is_z);
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (upd) begin
      cnt_d = cnt_q + 1'b1;
      if (is_nzv) flags_d = {alu_ovfl, alu_result[DW-1], res_zero};
      else        flags_d = {flags_q[2:1], res_zero};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      wr_q    <= upd;
      cnt_q   <= cnt_d;
    end
  end

  assign flags_out = flags_q;
  assign flags_fwd = flags_d;
  assign flags_wr  = wr_q;
  assign upd_count = cnt_q;

endmodule
